rr_select_arbiter: RTL
======================

Name: rr_select_arbiter

Overview:
- Round-robin arbiter that shares one DATA-wide output channel between IN requesters using valid/ready handshakes.
- Picks one requester per cycle and muxes its payload into a single-entry registered output stage.
- Reports the source index with each beat.
- Sits in front of any shared consumer (bus port, shared ALU, memory port) that takes one beat per cycle.

Parameters:
- DATA, 32, payload width per requester
- IN, 4, number of requesters (≥2)
- IDX, $clog2(IN), width of source index
- ACT, `HIGH, active level of req_valid/req_ready/out_valid/out_ready

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  IN  per-requester valid
- req_data  in  DATA*IN  payloads; requester i at [DATA*i +: DATA]
- req_ready  out  IN  per-requester accept (one-hot or zero)
- out_valid  out  1  output beat valid
- out_data  out  DATA  registered payload
- out_src  out  IDX  index of requester that produced out_data
- out_ready  in  1  consumer accept

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_src=0
  - rr pointer ptr=IN-1, so requester 0 has first priority
  - req_ready=0 while reset asserted
- Reset is asynchronous: assertion mid-transfer drops out_valid immediately and the held beat is lost.
- Output stage states:
  - EMPTY (out_valid=0)
  - FULL (out_valid=1)
- Stage can load when `load_ok = !out_valid | out_ready`.
- Pick:
  - Search req_valid starting at ptr+1, wrapping modulo IN.
  - First asserted bit is the grant g.
  - No valid request means no grant.
- req_ready[g] = load_ok & any_valid. All other req_ready bits are 0. Combinational from req_valid, out_valid, out_ready, ptr.
- On load (load_ok & any_valid), at the clock edge:
  - out_data ← req_data[g], out_src ← g, out_valid ← 1, ptr ← g.
- If out_valid & out_ready & no request, out_valid ← 0 and out_data/out_src are held.
- FULL & !out_ready:
  - out_data and out_src stay stable.
  - No req_ready is asserted.
  - ptr does not move.
- Latency: request accepted in cycle N appears on out_* in cycle N+1.
- Throughput: 1 beat/cycle with out_ready held high.
- Fairness:
  - A continuously valid requester is granted within IN accepted beats.
  - With all IN requesting and out_ready=1, grants cycle 0,1,2,…,IN-1,0.
- ptr advances only on an actual load. Idle cycles do not rotate priority.
- ptr wrap: ptr=IN-1 searches from 0.
- A requester dropping req_valid before being granted is legal; it is simply not picked.
- Requesters must hold req_data stable while req_valid=1 and req_ready=0. Behaviour is undefined if they do not.
- ACT=`LOW inverts the polarity of all four handshake signals at the ports. Internal logic is active-high.

Optional Feature:
- Macro: RR_SELECT_BURST_EN
- With the macro:
  - Adds input port req_last (IN bits).
  - After requester g is loaded with req_last[g]=0, the grant is locked to g.
  - Other requesters are masked until a beat from g with req_last[g]=1 is loaded.
  - ptr updates only on the last beat.
  - A locked requester dropping req_valid stalls the arbiter; no other grant is issued.
- Without the macro:
  - No req_last port.
  - Every beat is arbitrated independently, as described above.

Decomposition:
- Package rr_arb_pkg holds:
  - state encoding (EMPTY/FULL)
  - function rotate-find-first (vector, pointer) → index, valid
  - IDX derivation helper
- Sub-module rr_pick:
  - Combinational rotated priority encoder.
  - Inputs: req vector, ptr. Outputs: grant index, grant one-hot, any.
- Payload mux uses the team's existing selector module with binary select (SEL_WIDTH=IDX, MODE=`LOW), fed by rr_pick's index.

Test Plan:
- Reset/idle: assert reset, req_valid=0000 → out_valid=0, out_data=0, req_ready=0000; release reset; 5 idle cycles → ptr unchanged and first request from 0 is granted.
- Full rotation: req_data[i]=i+1, req_valid=1111, out_ready=1 → out_src sequence 0,1,2,3,0, out_data 1,2,3,4,1, one beat per cycle from N+1.
- Backpressure: out_valid=1, out_src=2, out_ready=0 for 3 cycles → out_data=3 held, req_ready=0000; then out_ready=1 → next grant is 3.
- Sparse/wrap: ptr=3, req_valid=0100 → grant 2; next req_valid=0011 → grant 0 (search 3,0).
- Async reset mid-transfer: out_valid=1, assert reset between edges → out_valid=0 immediately; after release, req_valid=1111 grants 0.
- RR_SELECT_BURST_EN: requester 1 sends 3 beats with last on beat 3 while others request → out_src=1,1,1 then 2.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_pkg
// Shared definitions for the round-robin select arbiter:
//   - `HIGH / `LOW handshake polarity macros
//   - output-stage state encoding (EMPTY / FULL)
//   - rr_idx_width(): source-index width derivation
//   - rr_find_first(): rotated find-first-set starting after a pointer
// No ports (package).
// ---------------------------------------------------------------------------
`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif

package rr_arb_pkg;

   // Upper bound on requester count handled by the search function.
   localparam int unsigned RR_MAX_IN  = 64;
   localparam int unsigned RR_IDX_MAX = 6;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } rr_state_e;

   typedef struct packed {
      logic                  valid;
      logic [RR_IDX_MAX-1:0] idx;
   } rr_find_t;

   // Width of an index able to address n requesters (at least one bit).
   function automatic int unsigned rr_idx_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Search vec[0 +: n] starting at ptr+1 and wrapping modulo n; return the
   // first set position. ptr is assumed < n, so one subtraction wraps.
   function automatic rr_find_t rr_find_first(input logic [RR_MAX_IN-1:0] vec,
                                              input int unsigned          ptr,
                                              input int unsigned          n);
      rr_find_t    res;
      int unsigned pos;
      res = '0;
      for (int unsigned k = 1; k <= RR_MAX_IN; k++) begin
         pos = ptr + k;
         if (pos >= n) pos = pos - n;
         if ((k <= n) && !res.valid && (pos < RR_MAX_IN) && vec[pos]) begin
            res.valid = 1'b1;
            res.idx   = pos[RR_IDX_MAX-1:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotated priority encoder: first set bit of i_req searching
// from i_ptr+1 upward, wrapping modulo IN.
// Ports:
//   i_req    [IN-1:0]   request vector (active-high)
//   i_ptr    [IDX-1:0]  last granted index
//   o_idx    [IDX-1:0]  grant index (0 when o_any=0)
//   o_onehot [IN-1:0]   grant as one-hot (zero when o_any=0)
//   o_any               at least one request present
// ---------------------------------------------------------------------------
module rr_pick
   import rr_arb_pkg::*;
#(
   parameter int unsigned IN  = 4,
   parameter int unsigned IDX = rr_idx_width(IN)
) (
   input  logic [IN-1:0]  i_req,
   input  logic [IDX-1:0] i_ptr,
   output logic [IDX-1:0] o_idx,
   output logic [IN-1:0]  o_onehot,
   output logic           o_any
);

   rr_find_t w_find;

   always_comb begin
      w_find   = rr_find_first(RR_MAX_IN'(i_req), 32'(i_ptr), IN);
      o_any    = w_find.valid;
      o_idx    = w_find.valid ? IDX'(w_find.idx) : '0;
      o_onehot = '0;
      if (w_find.valid) o_onehot[o_idx] = 1'b1;
   end

endmodule

// File: rtl/selector.sv
// ---------------------------------------------------------------------------
// selector
// Generic N-way payload selector.
//   MODE = `LOW  : i_sel is a binary index
//   MODE = `HIGH : i_sel is a one-hot vector (SEL_WIDTH must equal N)
// Ports:
//   i_data [WIDTH*N-1:0]  input words, word i at [WIDTH*i +: WIDTH]
//   i_sel  [SEL_WIDTH-1:0] select
//   o_data [WIDTH-1:0]    selected word (zero when nothing selected)
// ---------------------------------------------------------------------------
module selector #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned N         = 4,
   parameter int unsigned SEL_WIDTH = 2,
   parameter logic        MODE      = `LOW
) (
   input  logic [WIDTH*N-1:0]   i_data,
   input  logic [SEL_WIDTH-1:0] i_sel,
   output logic [WIDTH-1:0]     o_data
);

   generate
      if (MODE == `LOW) begin : g_binary
         always_comb begin
            // NOTE: assign a default before any conditional write so no latch is inferred.
            o_data = '0;
            for (int unsigned i = 0; i < N; i++) begin
               if (i_sel == SEL_WIDTH'(i)) o_data = i_data[WIDTH*i +: WIDTH];
            end
         end
      end else begin : g_onehot
         always_comb begin
            o_data = '0;
            for (int unsigned i = 0; i < N; i++) begin
               if ((i < SEL_WIDTH) && i_sel[i]) o_data = o_data | i_data[WIDTH*i +: WIDTH];
            end
         end
      end
   endgenerate

endmodule

// File: rtl/rr_select_arbiter.sv
// ---------------------------------------------------------------------------
// rr_select_arbiter
// Round-robin arbiter sharing one DATA-wide registered output channel among
// IN valid/ready requesters. One beat per cycle; accepted beat appears on
// out_* the following cycle together with its source index.
// Optional feature macro: RR_SELECT_BURST_EN (adds req_last; locks the grant
// to a requester until its last beat is loaded).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid [IN-1:0]         per-requester valid       (polarity ACT)
//   req_data  [DATA*IN-1:0]    payloads, requester i at [DATA*i +: DATA]
//   req_last  [IN-1:0]         burst last marker (RR_SELECT_BURST_EN only)
//   req_ready [IN-1:0]         per-requester accept      (polarity ACT)
//   out_valid                  output beat valid         (polarity ACT)
//   out_data  [DATA-1:0]       registered payload
//   out_src   [IDX-1:0]        source index of out_data
//   out_ready                  consumer accept           (polarity ACT)
// ---------------------------------------------------------------------------
module rr_select_arbiter
   import rr_arb_pkg::*;
#(
   parameter int unsigned DATA = 32,
   parameter int unsigned IN   = 4,
   parameter int unsigned IDX  = rr_idx_width(IN),
   parameter logic        ACT  = `HIGH
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IN-1:0]       req_valid,
   input  logic [DATA*IN-1:0]  req_data,
`ifdef RR_SELECT_BURST_EN
   input  logic [IN-1:0]       req_last,
`endif
   output logic [IN-1:0]       req_ready,
   output logic                out_valid,
   output logic [DATA-1:0]     out_data,
   output logic [IDX-1:0]      out_src,
   input  logic                out_ready
);

   rr_state_e        r_state;
   rr_state_e        w_state_nxt;
   logic [DATA-1:0]  r_out_data;
   logic [IDX-1:0]   r_out_src;
   logic [IDX-1:0]   r_ptr;

   logic [IN-1:0]    w_req_valid;
   logic             w_out_ready;
   logic [IN-1:0]    w_req_masked;
   logic [IDX-1:0]   w_grant_idx;
   logic [IN-1:0]    w_grant_oh;
   logic             w_any;
   logic             w_full;
   logic             w_load_ok;
   logic             w_load;
   logic             w_last;
   logic [IN-1:0]    w_ready;
   logic [DATA-1:0]  w_sel_data;

   // Ports carry ACT polarity; everything inside is active-high.
   assign w_req_valid = (ACT == `HIGH) ? req_valid : ~req_valid;
   assign w_out_ready = (ACT == `HIGH) ? out_ready : ~out_ready;

   assign w_full    = (r_state == ST_FULL);
   assign w_load_ok = !w_full || w_out_ready;

`ifdef RR_SELECT_BURST_EN
   logic           r_lock;
   logic [IDX-1:0] r_lock_idx;
   logic [IN-1:0]  w_lock_oh;

   // While a burst is open only the owning requester is visible to the picker,
   // so a locked requester dropping valid stalls arbitration.
   assign w_lock_oh    = IN'(1) << r_lock_idx;
   assign w_req_masked = r_lock ? (w_req_valid & w_lock_oh) : w_req_valid;
   assign w_last       = req_last[w_grant_idx];
`else
   assign w_req_masked = w_req_valid;
   assign w_last       = 1'b1;
`endif

   rr_pick #(
      .IN  (IN),
      .IDX (IDX)
   ) u_pick (
      .i_req    (w_req_masked),
      .i_ptr    (r_ptr),
      .o_idx    (w_grant_idx),
      .o_onehot (w_grant_oh),
      .o_any    (w_any)
   );

   selector #(
      .WIDTH     (DATA),
      .N         (IN),
      .SEL_WIDTH (IDX),
      .MODE      (`LOW)
   ) u_sel (
      .i_data (req_data),
      .i_sel  (w_grant_idx),
      .o_data (w_sel_data)
   );

   // Reset gates the accept so nothing is handshaken while reset is held.
   assign w_load  = w_load_ok && w_any && !reset;
   assign w_ready = w_load ? w_grant_oh : '0;

   assign req_ready = (ACT == `HIGH) ? w_ready : ~w_ready;
   assign out_valid = (ACT == `HIGH) ? w_full  : ~w_full;
   assign out_data  = r_out_data;
   assign out_src   = r_out_src;

   // Output-stage state register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (reset) r_state <= ST_EMPTY;
      else       r_state <= w_state_nxt;
   end

   // Output-stage next state.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_load) w_state_nxt = ST_FULL;
         ST_FULL: begin
            if (w_load)           w_state_nxt = ST_FULL;
            else if (w_out_ready) w_state_nxt = ST_EMPTY;
         end
         default:                 w_state_nxt = ST_EMPTY;
      endcase
   end

   // Payload, source and priority pointer. Data/src are held when the stage
   // drains with no new request; the pointer moves only on a real load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_data <= '0;
         r_out_src  <= '0;
         r_ptr      <= IDX'(IN - 1);
      end else if (w_load) begin
         r_out_data <= w_sel_data;
         r_out_src  <= w_grant_idx;
         if (w_last) r_ptr <= w_grant_idx;
      end
   end

`ifdef RR_SELECT_BURST_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lock     <= 1'b0;
         r_lock_idx <= '0;
      end else if (w_load) begin
         r_lock     <= !w_last;
         r_lock_idx <= w_grant_idx;
      end
   end
`endif

endmodule
